// File: rtl/regfile_dump_reader.sv
// Walks a contiguous register range through one synchronous register-file read port
// and streams every word out as an {address, data} pair on a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | one-cycle read strobe for cur
// WAIT    | counting read latency; captures rd_data on the last count
// PRESENT | word held on out_* until accepted
// FIN     | one-cycle done pulse
module regfile_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam bit CfgOk = (NUM_REGS >= 1) && (NUM_REGS <= (1 << ADDR_W)) &&
                         (RD_LAT >= 1) && (RD_LAT <= 3);
  localparam logic [1:0] LatLoad = 2'(RD_LAT - 1);

  generate
    if (!CfgOk) begin : gCfgErr
      $error("regfile_dump_reader: illegal NUM_REGS/ADDR_W/RD_LAT combination");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FIN} stateType;

  stateType          state, stateNxt;
  logic [ADDR_W-1:0] cur, endAddr, outAddrQ;
  logic [DATA_W-1:0] outDataQ;
  logic [1:0]        latCnt;
  logic              rdCapture, accept;

  always_comb begin
    stateNxt  = state;
    rdCapture = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE:
        if (start) stateNxt = (first_addr > last_addr) ? FIN : ISSUE;
      ISSUE:
        stateNxt = abort ? IDLE : WAIT;
      WAIT:
        if (abort) begin
          stateNxt = IDLE;
        end else if (latCnt == 2'd0) begin
          rdCapture = 1'b1;
          stateNxt  = PRESENT;
        end
      PRESENT:
        // abort wins over a same-cycle acceptance
        if (abort) begin
          stateNxt = IDLE;
        end else if (out_ready) begin
          accept   = 1'b1;
          stateNxt = (cur == endAddr) ? FIN : ISSUE;
        end
      FIN:
        stateNxt = IDLE;
      default:
        stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur      <= '0;
      endAddr  <= '0;
      latCnt   <= '0;
      outAddrQ <= '0;
      outDataQ <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE && start) begin
        cur     <= first_addr;
        endAddr <= last_addr;
      end
      // termination is on the cur==endAddr compare, so cur never needs to wrap
      if (accept && cur != endAddr) cur <= cur + 1'b1;
      if (state == ISSUE) begin
        latCnt <= LatLoad;
      end else if (state == WAIT && latCnt != 2'd0) begin
        latCnt <= latCnt - 1'b1;
      end
      if (rdCapture) begin
        outAddrQ <= cur;
        outDataQ <= rd_data;
      end
    end
  end

  assign rd_en     = (state == ISSUE);
  assign rd_addr   = (state == ISSUE) ? cur : '0;
  assign out_valid = (state == PRESENT);
  assign out_addr  = outAddrQ;
  assign out_data  = outDataQ;
  assign busy      = (state == ISSUE) || (state == WAIT) || (state == PRESENT);
  assign done      = (state == FIN);

  aDoneNotBusy: assert property (@(posedge clk) disable iff (!reset_n) !(done && busy));
  aRdEnSingle:  assert property (@(posedge clk) disable iff (!reset_n) rd_en |=> !rd_en);
  aHoldStall:   assert property (@(posedge clk) disable iff (!reset_n)
                  out_valid && !out_ready && !abort |=>
                  out_valid && $stable(out_addr) && $stable(out_data));

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: an RD_LAT=1 instance for all cases and an
// RD_LAT=3 instance for the latency-3 dump; register model R[i]=5*i.
module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          startA = 1'b0, startB = 1'b0, abort = 1'b0, outReady = 1'b1;
  logic [AW-1:0] firstAddr = '0, lastAddr = '0;

  logic          rdEnA, outValidA, busyA, doneA;
  logic [AW-1:0] rdAddrA, outAddrA;
  logic [DW-1:0] rdDataA, outDataA;
  logic          rdEnB, outValidB, busyB, doneB;
  logic [AW-1:0] rdAddrB, outAddrB;
  logic [DW-1:0] rdDataB, outDataB;

  always #5 clk = ~clk;

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .RD_LAT(1)) dutA (
    .clk(clk), .reset_n(reset_n), .start(startA), .abort(abort),
    .first_addr(firstAddr), .last_addr(lastAddr),
    .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA),
    .out_valid(outValidA), .out_ready(outReady), .out_addr(outAddrA), .out_data(outDataA),
    .busy(busyA), .done(doneA));

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .RD_LAT(3)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB), .abort(abort),
    .first_addr(firstAddr), .last_addr(lastAddr),
    .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB),
    .out_valid(outValidB), .out_ready(outReady), .out_addr(outAddrB), .out_data(outDataB),
    .busy(busyB), .done(doneB));

  // register-file models: data is only correct on the exact latency cycle
  logic [DW-1:0] pipeA;
  logic [DW-1:0] pipeB [3];
  always @(posedge clk) begin
    pipeA    <= rdEnA ? 32'(5 * int'(rdAddrA)) : 32'hDEADBEEF;
    pipeB[0] <= rdEnB ? 32'(5 * int'(rdAddrB)) : 32'hDEADBEEF;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign rdDataA = pipeA;
  assign rdDataB = pipeB[2];

  logic [35:0]   wordsA[$];
  logic [35:0]   wordsB[$];
  int            doneCntA = 0, doneCntB = 0, rdCntA = 0, bothViol = 0, stallViol = 0;
  logic          pV = 1'b0, pR = 1'b0, pAb = 1'b0;
  logic [AW-1:0] pAd = '0;
  logic [DW-1:0] pD = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pV = 1'b0;
    end else begin
      if (outValidA && outReady && !abort) wordsA.push_back({outAddrA, outDataA});
      if (outValidB && outReady && !abort) wordsB.push_back({outAddrB, outDataB});
      if (doneA) doneCntA++;
      if (doneB) doneCntB++;
      if (rdEnA) rdCntA++;
      if ((doneA && busyA) || (doneB && busyB)) bothViol++;
      if (pV && !pR && !pAb && !(outValidA && outAddrA == pAd && outDataA == pD)) stallViol++;
      pV = outValidA; pR = outReady; pAb = abort; pAd = outAddrA; pD = outDataA;
    end
  end

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input bit a, input bit b);
    firstAddr = f; lastAddr = l; startA = a; startB = b;
    cyc();
    startA = 1'b0; startB = 1'b0;
  endtask

  task automatic waitDone(input int tgtA, input int tgtB, input bit toggle, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (doneCntA >= tgtA && doneCntB >= tgtB) begin
        ok = 1'b1;
        break;
      end
      if (toggle) outReady = (k % 3 == 0);
      cyc();
    end
    outReady = 1'b1;
    chk("done_timeout", 64'(ok), 64'(1));
  endtask

  task automatic chkWords(input string tag, input bit useB, input int base,
                          input int first, input int span, input int n);
    int got = (useB ? wordsB.size() : wordsA.size()) - base;
    logic [35:0] w;
    chk({tag, "_count"}, 64'(got), 64'(n));
    for (int i = 0; i < n && i < got; i++) begin
      w = useB ? wordsB[base + i] : wordsA[base + i];
      chk({tag, "_addr"}, 64'(w[35:32]), 64'(first + i % span));
      chk({tag, "_data"}, 64'(w[31:0]), 64'(5 * (first + i % span)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bA, bB, dA, dB, rA;
    bit found;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(rdEnA), 64'(0));
    chk("rst_busy", 64'(busyA), 64'(0));
    chk("rst_done", 64'(doneA), 64'(0));
    chk("rst_out_valid", 64'(outValidA), 64'(0));
    chk("rst_out_addr", 64'(outAddrA), 64'(0));
    chk("rst_out_data", 64'(outDataA), 64'(0));
    reset_n = 1'b1;
    cyc();

    // 1: full range, ready held high, latency start->rd_en->valid = 1 -> 3
    bA = wordsA.size(); dA = doneCntA; rA = rdCntA;
    pulseStart(0, 15, 1'b1, 1'b0);
    chk("t1_rd_en_c1", 64'(rdEnA), 64'(1));
    chk("t1_rd_addr_c1", 64'(rdAddrA), 64'(0));
    chk("t1_busy_c1", 64'(busyA), 64'(1));
    cyc();
    chk("t1_rd_en_c2", 64'(rdEnA), 64'(0));
    chk("t1_valid_c2", 64'(outValidA), 64'(0));
    cyc();
    chk("t1_valid_c3", 64'(outValidA), 64'(1));
    waitDone(dA + 1, doneCntB, 1'b0, 200);
    chkWords("t1", 1'b0, bA, 0, 16, 16);
    chk("t1_done_cnt", 64'(doneCntA - dA), 64'(1));
    chk("t1_reads", 64'(rdCntA - rA), 64'(16));
    chk("t1_busy_after", 64'(busyA), 64'(0));

    // 2: ready 1 on / 2 off
    bA = wordsA.size(); dA = doneCntA;
    pulseStart(0, 15, 1'b1, 1'b0);
    waitDone(dA + 1, doneCntB, 1'b1, 400);
    chkWords("t2", 1'b0, bA, 0, 16, 16);
    chk("t2_stall_hold", 64'(stallViol), 64'(0));

    // 3: top-of-range pair, single word, empty range
    bA = wordsA.size(); dA = doneCntA;
    pulseStart(14, 15, 1'b1, 1'b0);
    waitDone(dA + 1, doneCntB, 1'b0, 100);
    chkWords("t3_pair", 1'b0, bA, 14, 16, 2);
    bA = wordsA.size(); dA = doneCntA;
    pulseStart(15, 15, 1'b1, 1'b0);
    waitDone(dA + 1, doneCntB, 1'b0, 100);
    chkWords("t3_single", 1'b0, bA, 15, 16, 1);
    repeat (3) cyc();
    chk("t3_no_wrap_busy", 64'(busyA), 64'(0));
    bA = wordsA.size(); dA = doneCntA; rA = rdCntA;
    pulseStart(9, 3, 1'b1, 1'b0);
    chk("t3_empty_done", 64'(doneA), 64'(1));
    chk("t3_empty_busy", 64'(busyA), 64'(0));
    cyc();
    chk("t3_empty_done_off", 64'(doneA), 64'(0));
    chk("t3_empty_done_cnt", 64'(doneCntA - dA), 64'(1));
    chk("t3_empty_reads", 64'(rdCntA - rA), 64'(0));
    chk("t3_empty_words", 64'(wordsA.size() - bA), 64'(0));

    // 4: abort while word 6 is presented, ready also high
    bA = wordsA.size(); dA = doneCntA;
    pulseStart(0, 15, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (outValidA && outAddrA == 4'd6) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("t4_reached_addr6", 64'(found), 64'(1));
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_busy", 64'(busyA), 64'(0));
    chk("t4_valid", 64'(outValidA), 64'(0));
    chk("t4_rd_en", 64'(rdEnA), 64'(0));
    repeat (4) cyc();
    chk("t4_no_done", 64'(doneCntA - dA), 64'(0));
    chkWords("t4_pre", 1'b0, bA, 0, 16, 6);
    bA = wordsA.size(); dA = doneCntA;
    pulseStart(10, 12, 1'b1, 1'b0);
    waitDone(dA + 1, doneCntB, 1'b0, 100);
    chkWords("t4_restart", 1'b0, bA, 10, 16, 3);

    // 5: reset asserted mid-cycle while waiting on the read of addr 5
    pulseStart(0, 15, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rdEnA && rdAddrA == 4'd5) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("t5_reached_rd5", 64'(found), 64'(1));
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rd_en", 64'(rdEnA), 64'(0));
    chk("t5_rst_rd_addr", 64'(rdAddrA), 64'(0));
    chk("t5_rst_busy", 64'(busyA), 64'(0));
    chk("t5_rst_out_addr", 64'(outAddrA), 64'(0));
    chk("t5_rst_out_data", 64'(outDataA), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bA = wordsA.size(); dA = doneCntA;
    repeat (5) cyc();
    chk("t5_idle_busy", 64'(busyA), 64'(0));
    chk("t5_no_done", 64'(doneCntA - dA), 64'(0));
    chk("t5_no_word", 64'(wordsA.size() - bA), 64'(0));

    bA = wordsA.size(); bB = wordsB.size(); dA = doneCntA; dB = doneCntB;
    pulseStart(0, 15, 1'b1, 1'b1);
    chk("t5_b_rd_en_c1", 64'(rdEnB), 64'(1));
    cyc();
    cyc();
    chk("t5_a_valid_c3", 64'(outValidA), 64'(1));
    chk("t5_b_valid_c3", 64'(outValidB), 64'(0));
    cyc();
    chk("t5_b_valid_c4", 64'(outValidB), 64'(0));
    cyc();
    chk("t5_b_valid_c5", 64'(outValidB), 64'(1));
    waitDone(dA + 1, dB + 1, 1'b0, 300);
    chkWords("t5_lat1", 1'b0, bA, 0, 16, 16);
    chkWords("t5_lat3", 1'b1, bB, 0, 16, 16);
    chk("t5_lat3_done_cnt", 64'(doneCntB - dB), 64'(1));

    // 6: start held for 40 edges over 0..3 -> dumps begin on edges 1, 15, 29
    bA = wordsA.size(); dA = doneCntA; rA = rdCntA;
    firstAddr = 4'd0; lastAddr = 4'd3; startA = 1'b1;
    repeat (40) cyc();
    startA = 1'b0;
    waitDone(dA + 3, doneCntB, 1'b0, 100);
    repeat (3) cyc();
    chk("t6_done_cnt", 64'(doneCntA - dA), 64'(3));
    chk("t6_reads", 64'(rdCntA - rA), 64'(12));
    chk("t6_busy_after", 64'(busyA), 64'(0));
    chkWords("t6", 1'b0, bA, 0, 4, 12);

    chk("done_busy_overlap", 64'(bothViol), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
